// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
//   Shared definitions for the boot loader: the loader state encoding and the
//   fixed length-header size of the incoming image stream.
// ---------------------------------------------------------------------------
package boot_pkg;

   typedef enum logic [2:0] {
      SLen,
      SSum,
      SData,
      SRun,
      SError
   } state_t;

   // Number of little-endian bytes carrying the image word count
   localparam int unsigned LEN_BYTES = 4;

endpackage : boot_pkg

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//   Byte-stream program loader and reset sequencer for the RV32I core.
//   It holds the core in reset and owns the memory write port while an image
//   arrives as <len:4 bytes LE><data:4*len bytes><checksum:1 byte>.
//   Data bytes are written one byte lane at a time. Once the checksum
//   matches, the core is released and the memory port is handed over to it.
//
// Ports
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_rx_valid, i_rx_data     : incoming byte stream (valid/ready)
//   o_rx_ready                : loader accepts a byte this cycle
//   o_cpu_reset               : reset to the core (low only while running)
//   i_cpu_bus_addr/_data_w/_mask_w : core-side write port
//   o_mem_addr/_data_w/_mask_w     : memory write port (loader or core)
//   o_loaded                  : image accepted, core running
//   o_error                   : bad length or checksum (sticky until reset)
// ---------------------------------------------------------------------------
module boot_loader
   import boot_pkg::*;
#(
   parameter logic [29:0] BASE_WADDR = 30'd0,
   parameter int unsigned MAX_WORDS  = 4096
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_data,
   output logic        o_rx_ready,
   output logic        o_cpu_reset,
   input  logic [29:0] i_cpu_bus_addr,
   input  logic [31:0] i_cpu_bus_data_w,
   input  logic [3:0]  i_cpu_bus_mask_w,
   output logic [29:0] o_mem_addr,
   output logic [31:0] o_mem_data_w,
   output logic [3:0]  o_mem_mask_w,
   output logic        o_loaded,
   output logic        o_error
);

   // Byte counter must be able to hold 4*MAX_WORDS
   localparam int unsigned CW = $clog2(4 * MAX_WORDS + 1);

   state_t          r_state;
   state_t          w_state_n;
   logic [31:0]     r_len;
   logic [1:0]      r_lcnt;
   logic [CW-1:0]   r_bcnt;
   logic [7:0]      r_sum;
   logic [29:0]     r_wr_addr;
   logic [31:0]     r_wr_data;
   logic [3:0]      r_wr_mask;
   logic            r_cpu_reset;

   logic            w_hs;
   logic            w_len_last;
   logic [31:0]     w_len_full;
   logic [CW-1:0]   w_total;
   logic            w_data_last;

   assign w_hs        = i_rx_valid & o_rx_ready;
   assign w_len_last  = (r_lcnt == 2'(LEN_BYTES - 1));
   // The 4th length byte is still on the bus when the length is judged
   assign w_len_full  = {i_rx_data, r_len[23:0]};
   // len <= MAX_WORDS is guaranteed in SData, so truncation to CW is exact
   assign w_total     = CW'({r_len, 2'b00});
   assign w_data_last = (r_bcnt == (w_total - CW'(1)));

   // ---------------- state register ----------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= SLen;
      end else begin
         r_state <= w_state_n;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_n = r_state;
      case (r_state)
         SLen: begin
            if (w_hs && w_len_last) begin
               if (w_len_full > 32'(MAX_WORDS)) begin
                  w_state_n = SError;
               end else if (w_len_full == 32'd0) begin
                  w_state_n = SSum;
               end else begin
                  w_state_n = SData;
               end
            end
         end
         SData: begin
            if (w_hs && w_data_last) begin
               w_state_n = SSum;
            end
         end
         SSum: begin
            if (w_hs) begin
               w_state_n = (i_rx_data == r_sum) ? SRun : SError;
            end
         end
         SRun:    w_state_n = SRun;
         SError:  w_state_n = SError;
         default: w_state_n = state_t'('x);
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_len       <= '0;
         r_lcnt      <= '0;
         r_bcnt      <= '0;
         r_sum       <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_mask   <= '0;
         r_cpu_reset <= 1'b1;
      end else begin
         // Registered from the next state so the core leaves reset on the
         // same edge that accepts the checksum byte
         r_cpu_reset <= (w_state_n != SRun);
         // Write strobe lasts exactly one cycle per accepted data byte
         r_wr_mask   <= '0;
         case (r_state)
            SLen: begin
               if (w_hs) begin
                  r_len[{r_lcnt, 3'b000} +: 8] <= i_rx_data;
                  r_lcnt                       <= r_lcnt + 2'd1;
                  r_bcnt                       <= '0;
               end
            end
            SData: begin
               if (w_hs) begin
                  r_wr_addr <= BASE_WADDR + 30'(r_bcnt[CW-1:2]);
                  r_wr_mask <= 4'b0001 << r_bcnt[1:0];
                  r_wr_data <= {4{i_rx_data}};
                  r_sum     <= r_sum + i_rx_data;
                  r_bcnt    <= r_bcnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- output logic ----------------
   always_comb begin
      o_rx_ready   = (r_state == SLen) || (r_state == SData) || (r_state == SSum);
      o_loaded     = (r_state == SRun);
      o_error      = (r_state == SError);
      o_cpu_reset  = r_cpu_reset;
      o_mem_addr   = r_wr_addr;
      o_mem_data_w = r_wr_data;
      o_mem_mask_w = r_wr_mask;
      if (r_state == SRun) begin
         o_mem_addr   = i_cpu_bus_addr;
         o_mem_data_w = i_cpu_bus_data_w;
         o_mem_mask_w = i_cpu_bus_mask_w;
      end else if (r_state == SError) begin
         o_mem_mask_w = '0;
      end
   end

endmodule : boot_loader

// File: tb/tb_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_boot_loader
//   Self-checking bench for boot_loader. Expected memory writes are queued
//   as each data byte is driven and compared when the write appears.
// ---------------------------------------------------------------------------
module tb_boot_loader;

   localparam logic [29:0] BASE = 30'd0;

   typedef struct {
      logic [29:0] a;
      logic [3:0]  m;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_rx_valid = 1'b0;
   logic [7:0]  i_rx_data = '0;
   logic [29:0] i_cpu_bus_addr = '0;
   logic [31:0] i_cpu_bus_data_w = '0;
   logic [3:0]  i_cpu_bus_mask_w = '0;
   logic        o_rx_ready, o_cpu_reset, o_loaded, o_error;
   logic [29:0] o_mem_addr;
   logic [31:0] o_mem_data_w;
   logic [3:0]  o_mem_mask_w;

   wr_t  exp_q[$];
   int   checks = 0;
   int   failures = 0;
   logic [7:0] sum;

   always #5 clk = ~clk;

   boot_loader #(.BASE_WADDR(BASE), .MAX_WORDS(4096)) dut (
      .i_clock          (clk),
      .i_reset          (i_reset),
      .i_rx_valid       (i_rx_valid),
      .i_rx_data        (i_rx_data),
      .o_rx_ready       (o_rx_ready),
      .o_cpu_reset      (o_cpu_reset),
      .i_cpu_bus_addr   (i_cpu_bus_addr),
      .i_cpu_bus_data_w (i_cpu_bus_data_w),
      .i_cpu_bus_mask_w (i_cpu_bus_mask_w),
      .o_mem_addr       (o_mem_addr),
      .o_mem_data_w     (o_mem_data_w),
      .o_mem_mask_w     (o_mem_mask_w),
      .o_loaded         (o_loaded),
      .o_error          (o_error)
   );

   // Write monitor: every loader write must match the head of the queue
   always @(negedge clk) begin
      wr_t e;
      if (o_loaded !== 1'b1 && o_mem_mask_w !== 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%h mask=%b data=%h required=no write",
                     o_mem_addr, o_mem_mask_w, o_mem_data_w);
         end else begin
            e = exp_q.pop_front();
            if (o_mem_addr !== e.a || o_mem_mask_w !== e.m || o_mem_data_w !== e.d) begin
               failures++;
               $display("FAIL write got addr=%h mask=%b data=%h required addr=%h mask=%b data=%h",
                        o_mem_addr, o_mem_mask_w, o_mem_data_w, e.a, e.m, e.d);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      @(posedge clk);
      #1;
      i_rx_valid = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] n);
      for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8]);
   endtask

   task automatic send_data(input logic [7:0] b, input int idx);
      exp_q.push_back('{a: BASE + 30'(idx >> 2), m: 4'(1 << (idx % 4)), d: {4{b}}});
      sum = sum + b;
      send_byte(b);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      i_reset = 1'b1;
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      sum = '0;
   endtask

   task automatic check_drained(input string name);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_pending_writes got=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_status(input string name, input logic rdy, input logic crst,
                               input logic ld, input logic err);
      checks++;
      if (o_rx_ready !== rdy || o_cpu_reset !== crst || o_loaded !== ld || o_error !== err) begin
         failures++;
         $display("FAIL %s got rdy=%b cpu_reset=%b loaded=%b error=%b required rdy=%b cpu_reset=%b loaded=%b error=%b",
                  name, o_rx_ready, o_cpu_reset, o_loaded, o_error, rdy, crst, ld, err);
      end
   endtask

   task automatic check_passthrough(input string name);
      for (int k = 0; k < 3; k++) begin
         i_cpu_bus_addr   = 30'($urandom);
         i_cpu_bus_data_w = $urandom;
         i_cpu_bus_mask_w = 4'($urandom_range(1, 15));
         #1;
         checks++;
         if (o_mem_addr !== i_cpu_bus_addr || o_mem_data_w !== i_cpu_bus_data_w ||
             o_mem_mask_w !== i_cpu_bus_mask_w) begin
            failures++;
            $display("FAIL %s got addr=%h data=%h mask=%b required addr=%h data=%h mask=%b",
                     name, o_mem_addr, o_mem_data_w, o_mem_mask_w,
                     i_cpu_bus_addr, i_cpu_bus_data_w, i_cpu_bus_mask_w);
         end
         idle(1);
      end
   endtask

   task automatic test_reset;
      do_reset();
      check_status("reset_status", 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (o_mem_mask_w !== 4'b0 || o_mem_addr !== 30'd0 || o_mem_data_w !== 32'd0) begin
         failures++;
         $display("FAIL reset_mem got addr=%h data=%h mask=%b required all zero",
                  o_mem_addr, o_mem_data_w, o_mem_mask_w);
      end
   endtask

   task automatic load_image(input logic [7:0] img[8]);
      send_len(32'd2);
      for (int i = 0; i < 8; i++) send_data(img[i], i);
   endtask

   task automatic test_load_ok;
      logic [7:0] img[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      do_reset();
      load_image(img);
      check_status("ok_before_sum", 1'b1, 1'b1, 1'b0, 1'b0);
      send_byte(sum);
      check_status("ok_after_sum", 1'b0, 1'b0, 1'b1, 1'b0);
      check_drained("ok");
      check_passthrough("ok_passthrough");
      // Stream is ignored while running
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h55;
      idle(3);
      i_rx_valid = 1'b0;
      check_status("ok_run_ignores_rx", 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_bad_sum;
      logic [7:0] img[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      do_reset();
      load_image(img);
      send_byte(sum + 8'd1);
      check_status("bad_sum_error", 1'b0, 1'b1, 1'b0, 1'b1);
      check_drained("bad_sum");
      // Core bus activity and further bytes must not reach memory
      i_cpu_bus_mask_w = 4'hF;
      i_rx_valid = 1'b1;
      idle(4);
      i_rx_valid = 1'b0;
      i_cpu_bus_mask_w = 4'h0;
      check_status("bad_sum_sticky", 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_len_limits;
      do_reset();
      send_len(32'h0000_1001);
      check_status("len_too_big", 1'b0, 1'b1, 1'b0, 1'b1);
      check_drained("len_too_big");
      do_reset();
      send_len(32'd4096);
      check_status("len_max_ok", 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_len_zero;
      do_reset();
      send_len(32'd0);
      check_status("len0_before_sum", 1'b1, 1'b1, 1'b0, 1'b0);
      send_byte(8'h00);
      check_status("len0_run", 1'b0, 1'b0, 1'b1, 1'b0);
      check_drained("len0");
   endtask

   task automatic test_gapped;
      do_reset();
      send_len(32'd3);
      for (int i = 0; i < 12; i++) begin
         send_data(8'($urandom), i);
         idle(1);
      end
      send_byte(sum);
      check_status("gapped_run", 1'b0, 1'b0, 1'b1, 1'b0);
      check_drained("gapped");
   endtask

   task automatic test_back_to_back_reset;
      logic [7:0] img[8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
      do_reset();
      send_len(32'd2);
      for (int i = 0; i < 3; i++) send_data(8'h40 + 8'(i), i);
      do_reset();
      check_drained("midload");
      check_status("midload_restart", 1'b1, 1'b1, 1'b0, 1'b0);
      load_image(img);
      send_byte(sum);
      check_status("restart_run", 1'b0, 1'b0, 1'b1, 1'b0);
      check_drained("restart");
      // Reset while running puts the core back into reset immediately
      do_reset();
      check_status("midrun_reset", 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (o_mem_addr !== 30'd0 || o_mem_mask_w !== 4'b0) begin
         failures++;
         $display("FAIL midrun_mem got addr=%h mask=%b required addr=0 mask=0",
                  o_mem_addr, o_mem_mask_w);
      end
   endtask

   initial begin
      sum = '0;
      test_reset();
      test_load_ok();
      test_bad_sum();
      test_len_limits();
      test_len_zero();
      test_gapped();
      test_back_to_back_reset();
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_boot_loader
